// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the SM83 instruction fetch stage and its decoder:
//   - fetch_state_e   : fetch FSM state encoding
//   - CB_PREFIX       : the CB prefix opcode
//   - op_len()        : instruction length in bytes (1..3) implied by an opcode
//   - op_illegal()    : opcode is one of the unused SM83 slots
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [2:0] {
        FETCH_OP = 3'd0,
        FETCH_CB = 3'd1,
        FETCH_LO = 3'd2,
        FETCH_HI = 3'd3,
        HOLD     = 3'd4
    } fetch_state_e;

    localparam logic [7:0] CB_PREFIX = 8'hCB;

    // Total bytes of an unprefixed instruction. The CB prefix itself reports
    // 1 here; the fetch FSM accounts for the second byte separately.
    function automatic logic [1:0] op_len(input logic [7:0] op);
        logic [1:0] len;
        case (op)
            8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
            8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
            8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
            8'hE0, 8'hF0, 8'hE8, 8'hF8:                 len = 2'd2;
            8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
            8'hC2, 8'hC3, 8'hCA, 8'hD2, 8'hDA,
            8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC,
            8'hEA, 8'hFA:                               len = 2'd3;
            default:                                    len = 2'd1;
        endcase
        return len;
    endfunction

    function automatic logic op_illegal(input logic [7:0] op);
        logic ill;
        case (op)
            8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
            8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD:          ill = 1'b1;
            default:                                    ill = 1'b0;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/instr_len_decode.sv
// -----------------------------------------------------------------------------
// instr_len_decode
// Combinational opcode classifier shared between fetch and decode.
//   op_i       in  8  first instruction byte
//   len_o      out 2  instruction length in bytes (1..3); CB prefix reports 1
//   illegal_o  out 1  opcode is an unused SM83 slot
//   cb_o       out 1  opcode is the CB prefix
// -----------------------------------------------------------------------------
module instr_len_decode
    import fetch_pkg::*;
(
    input  logic [7:0] op_i,
    output logic [1:0] len_o,
    output logic       illegal_o,
    output logic       cb_o
);

    assign len_o     = op_len(op_i);
    assign illegal_o = op_illegal(op_i);
    assign cb_o      = (op_i == CB_PREFIX);

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// SM83 instruction fetch stage; sole master of the 64 KiB unified memory port
// (async read, sync write). Reads one byte per cycle at the PC, assembles
// opcode / CB prefix / imm8 / imm16 and offers the instruction to the decoder
// over instr_valid/instr_ready. Execute-stage loads and stores take the memory
// port with priority (fetch stalls that cycle). Execute redirects reload the
// PC and flush any partially fetched instruction.
//
// Optional build macro: INSTR_PREFETCH_EN adds a one-byte prefetch buffer that
// reads the next opcode while an instruction waits in HOLD.
//
// Parameters
//   RESET_PC        PC loaded on reset
// Ports
//   clk, rst        clock, synchronous active-high reset
//   mem_adr         out 16  memory address (0 while in reset)
//   mem_rdata       in   8  memory read data, combinational from mem_adr
//   mem_wr_en       out  1  memory write enable
//   mem_wdata       out  8  memory write data
//   exe_req/we/adr/wdata    execute-stage access (we: 1 = store)
//   exe_rdata       out  8  load data (same cycle as exe_req)
//   redirect_valid/pc       load new PC, flush in-progress instruction
//   instr_valid/ready       decoder handshake
//   instr_op        out  8  opcode (second byte when instr_cb)
//   instr_cb        out  1  CB-prefixed instruction
//   instr_imm       out 16  immediate {hi,lo}; imm8 zero-extended
//   instr_len       out  2  bytes consumed (1..3)
//   instr_pc        out 16  address of the first byte
//   instr_illegal   out  1  unused opcode
// -----------------------------------------------------------------------------
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] mem_adr,
    input  logic [7:0]  mem_rdata,
    output logic        mem_wr_en,
    output logic [7:0]  mem_wdata,
    input  logic        exe_req,
    input  logic        exe_we,
    input  logic [15:0] exe_adr,
    input  logic [7:0]  exe_wdata,
    output logic [7:0]  exe_rdata,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  instr_op,
    output logic        instr_cb,
    output logic [15:0] instr_imm,
    output logic [1:0]  instr_len,
    output logic [15:0] instr_pc,
    output logic        instr_illegal
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [7:0]   op_q, op_d;
    logic         cb_q, cb_d;
    logic [15:0]  imm_q, imm_d;
    logic [1:0]   len_q, len_d;
    logic [15:0]  ipc_q, ipc_d;
    logic         ill_q, ill_d;
    logic         valid_q, valid_d;

    logic [15:0]  pc_inc;
    logic [7:0]   op_src;
    logic [1:0]   dec_len;
    logic         dec_ill;
    logic         dec_cb;
    fetch_state_e op_next;

`ifdef INSTR_PREFETCH_EN
    logic         pf_valid_q, pf_valid_d;
    logic [7:0]   pf_byte_q, pf_byte_d;
    logic [15:0]  pf_adr_q, pf_adr_d;
    logic         pf_hit;     // store overwrites the buffered byte
    logic         pf_fill;    // HOLD borrows the idle port to read ahead
    logic         have_byte;
    logic [7:0]   hold_byte;
    logic [15:0]  hold_adr;

    assign pf_hit    = pf_valid_q & exe_req & exe_we & (exe_adr == pf_adr_q);
    assign pf_fill   = (state_q == HOLD) & ~pf_valid_q & ~exe_req;
    assign have_byte = (pf_valid_q & ~pf_hit) | pf_fill;
    assign hold_byte = pf_valid_q ? pf_byte_q : mem_rdata;
    assign hold_adr  = pf_valid_q ? pf_adr_q  : pc_q;
    // In HOLD the decoder looks at the buffered/read-ahead byte.
    assign op_src    = (state_q == HOLD) ? hold_byte : mem_rdata;
`else
    assign op_src    = mem_rdata;
`endif

    // ------------------------------------------------------------------
    // Memory port mux: execute access wins over fetch.
    // ------------------------------------------------------------------
    assign mem_adr   = rst ? 16'h0000 : (exe_req ? exe_adr : pc_q);
    assign mem_wr_en = ~rst & exe_req & exe_we;
    assign mem_wdata = exe_wdata;
    assign exe_rdata = mem_rdata;

    assign pc_inc = pc_q + 16'd1;   // wraps FFFF -> 0000

    instr_len_decode u_len_decode (
        .op_i      (op_src),
        .len_o     (dec_len),
        .illegal_o (dec_ill),
        .cb_o      (dec_cb)
    );

    // State reached after an opcode byte has been captured.
    always_comb begin
        if (dec_cb)                op_next = FETCH_CB;
        else if (dec_len != 2'd1)  op_next = FETCH_LO;
        else                       op_next = HOLD;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every _d signal is given its hold value first, so no path through
    // this block leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        op_d    = op_q;
        cb_d    = cb_q;
        imm_d   = imm_q;
        len_d   = len_q;
        ipc_d   = ipc_q;
        ill_d   = ill_q;
        valid_d = valid_q;
`ifdef INSTR_PREFETCH_EN
        pf_valid_d = pf_valid_q;
        pf_byte_d  = pf_byte_q;
        pf_adr_d   = pf_adr_q;
`endif

        if (redirect_valid) begin
            // Any partial instruction is dropped; a handshake this cycle
            // has already completed on the decoder side.
            pc_d    = redirect_pc;
            state_d = FETCH_OP;
            valid_d = 1'b0;
`ifdef INSTR_PREFETCH_EN
            pf_valid_d = 1'b0;
`endif
        end else begin
            case (state_q)
                FETCH_OP: if (!exe_req) begin
                    op_d    = mem_rdata;
                    ipc_d   = pc_q;
                    cb_d    = 1'b0;
                    imm_d   = 16'h0000;
                    len_d   = dec_len;
                    ill_d   = dec_ill;
                    pc_d    = pc_inc;
                    state_d = op_next;
                    valid_d = (op_next == HOLD);
                end
                FETCH_CB: if (!exe_req) begin
                    op_d    = mem_rdata;
                    cb_d    = 1'b1;
                    len_d   = 2'd2;
                    ill_d   = 1'b0;
                    pc_d    = pc_inc;
                    state_d = HOLD;
                    valid_d = 1'b1;
                end
                FETCH_LO: if (!exe_req) begin
                    imm_d = {8'h00, mem_rdata};
                    pc_d  = pc_inc;
                    if (len_q == 2'd3) begin
                        state_d = FETCH_HI;
                    end else begin
                        state_d = HOLD;
                        valid_d = 1'b1;
                    end
                end
                FETCH_HI: if (!exe_req) begin
                    imm_d[15:8] = mem_rdata;
                    pc_d        = pc_inc;
                    state_d     = HOLD;
                    valid_d     = 1'b1;
                end
                HOLD: begin
`ifdef INSTR_PREFETCH_EN
                    if (pf_hit) begin
                        // Buffered byte is stale; refetch it from memory.
                        pf_valid_d = 1'b0;
                        pc_d       = pf_adr_q;
                    end
                    if (instr_ready) begin
                        if (have_byte) begin
                            // Skip FETCH_OP: decode the held byte directly.
                            op_d       = hold_byte;
                            ipc_d      = hold_adr;
                            cb_d       = 1'b0;
                            imm_d      = 16'h0000;
                            len_d      = dec_len;
                            ill_d      = dec_ill;
                            state_d    = op_next;
                            valid_d    = (op_next == HOLD);
                            pf_valid_d = 1'b0;
                            if (pf_fill) pc_d = pc_inc;
                        end else begin
                            state_d = FETCH_OP;
                            valid_d = 1'b0;
                        end
                    end else if (pf_fill) begin
                        pf_valid_d = 1'b1;
                        pf_byte_d  = mem_rdata;
                        pf_adr_d   = pc_q;
                        pc_d       = pc_inc;
                    end
`else
                    // Acceptance does not use the memory port, so it is
                    // honoured even while execute owns the port.
                    if (instr_ready) begin
                        state_d = FETCH_OP;
                        valid_d = 1'b0;
                    end
`endif
                end
                default: begin
                    state_d = FETCH_OP;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its _d value from before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH_OP;
            pc_q    <= RESET_PC;
            op_q    <= 8'h00;
            cb_q    <= 1'b0;
            imm_q   <= 16'h0000;
            len_q   <= 2'd1;
            ipc_q   <= 16'h0000;
            ill_q   <= 1'b0;
            valid_q <= 1'b0;
`ifdef INSTR_PREFETCH_EN
            pf_valid_q <= 1'b0;
            pf_byte_q  <= 8'h00;
            pf_adr_q   <= 16'h0000;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            op_q    <= op_d;
            cb_q    <= cb_d;
            imm_q   <= imm_d;
            len_q   <= len_d;
            ipc_q   <= ipc_d;
            ill_q   <= ill_d;
            valid_q <= valid_d;
`ifdef INSTR_PREFETCH_EN
            pf_valid_q <= pf_valid_d;
            pf_byte_q  <= pf_byte_d;
            pf_adr_q   <= pf_adr_d;
`endif
        end
    end

    assign instr_valid   = valid_q;
    assign instr_op      = op_q;
    assign instr_cb      = cb_q;
    assign instr_imm     = imm_q;
    assign instr_len     = len_q;
    assign instr_pc      = ipc_q;
    assign instr_illegal = ill_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch with a behavioural 64 KiB memory
// (async read, sync write). Cycle-exact sequences target the default build;
// the prefetch-buffer sequence is built when INSTR_PREFETCH_EN is defined.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem_adr;
    logic [7:0]  mem_rdata;
    logic        mem_wr_en;
    logic [7:0]  mem_wdata;
    logic        exe_req;
    logic        exe_we;
    logic [15:0] exe_adr;
    logic [7:0]  exe_wdata;
    logic [7:0]  exe_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr_op;
    logic        instr_cb;
    logic [15:0] instr_imm;
    logic [1:0]  instr_len;
    logic [15:0] instr_pc;
    logic        instr_illegal;

    logic [7:0] mem [0:65535];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_adr];
    always @(posedge clk) if (mem_wr_en) mem[mem_adr] <= mem_wdata;

    instr_fetch #(.RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_adr        (mem_adr),
        .mem_rdata      (mem_rdata),
        .mem_wr_en      (mem_wr_en),
        .mem_wdata      (mem_wdata),
        .exe_req        (exe_req),
        .exe_we         (exe_we),
        .exe_adr        (exe_adr),
        .exe_wdata      (exe_wdata),
        .exe_rdata      (exe_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_op       (instr_op),
        .instr_cb       (instr_cb),
        .instr_imm      (instr_imm),
        .instr_len      (instr_len),
        .instr_pc       (instr_pc),
        .instr_illegal  (instr_illegal)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    endtask

    // Leaves the bench in cycle 0 of a fresh FETCH_OP at RESET_PC.
    task automatic do_reset();
        rst = 1'b1;
        exe_req = 1'b0; exe_we = 1'b0; exe_adr = 16'h0000; exe_wdata = 8'h00;
        redirect_valid = 1'b0; redirect_pc = 16'h0000; instr_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic redirect_to(input logic [15:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n;
        n = 0;
        while (instr_valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (instr_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s: instr_valid not seen within %0d cycles", name, budget);
        end
    endtask

    typedef struct {
        logic        valid;
        logic [7:0]  op;
        logic [15:0] imm;
        logic [1:0]  len;
        logic [15:0] pc;
    } vec_t;

    vec_t tbl [8];

    initial begin
        // ---------------- reset state ----------------
        clear_mem();
        rst = 1'b1;
        exe_req = 1'b1; exe_we = 1'b1; exe_adr = 16'h1234; exe_wdata = 8'h77;
        redirect_valid = 1'b0; redirect_pc = 16'h0000; instr_ready = 1'b0;
        tick();
        check("rst_mem_adr",   mem_adr,       16'h0000);
        check("rst_wr_en",     mem_wr_en,     1'b0);
        check("rst_valid",     instr_valid,   1'b0);
        check("rst_len",       instr_len,     2'd1);
        check("rst_op",        instr_op,      8'h00);
        check("rst_imm",       instr_imm,     16'h0000);
        check("rst_pc",        instr_pc,      16'h0000);
        check("rst_cb",        instr_cb,      1'b0);
        check("rst_illegal",   instr_illegal, 1'b0);
        tick();
        check("rst_no_write",  mem[16'h1234], 8'h00);

`ifndef INSTR_PREFETCH_EN
        // ---------------- C6 A1 D6 01 04, ready high ----------------
        mem[0] = 8'hC6; mem[1] = 8'hA1; mem[2] = 8'hD6; mem[3] = 8'h01; mem[4] = 8'h04;
        tbl[0] = '{1'b0, 8'h00, 16'h0000, 2'd1, 16'h0000};
        tbl[1] = '{1'b0, 8'h00, 16'h0000, 2'd1, 16'h0000};
        tbl[2] = '{1'b1, 8'hC6, 16'h00A1, 2'd2, 16'h0000};
        tbl[3] = '{1'b0, 8'h00, 16'h0000, 2'd1, 16'h0000};
        tbl[4] = '{1'b0, 8'h00, 16'h0000, 2'd1, 16'h0000};
        tbl[5] = '{1'b1, 8'hD6, 16'h0001, 2'd2, 16'h0002};
        tbl[6] = '{1'b0, 8'h00, 16'h0000, 2'd1, 16'h0000};
        tbl[7] = '{1'b1, 8'h04, 16'h0000, 2'd1, 16'h0004};
        do_reset();
        instr_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            check($sformatf("seq1_valid_c%0d", c), instr_valid, tbl[c].valid);
            if (tbl[c].valid) begin
                check($sformatf("seq1_op_c%0d", c),  instr_op,  tbl[c].op);
                check($sformatf("seq1_imm_c%0d", c), instr_imm, tbl[c].imm);
                check($sformatf("seq1_len_c%0d", c), instr_len, tbl[c].len);
                check($sformatf("seq1_pc_c%0d", c),  instr_pc,  tbl[c].pc);
            end
            tick();
        end
        instr_ready = 1'b0;

        // ---------------- FA DD DD, ready low 5 cycles ----------------
        clear_mem();
        mem[0] = 8'hFA; mem[1] = 8'hDD; mem[2] = 8'hDD;
        do_reset();
        wait_valid("hold_wait", 10);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("hold_valid_%0d", c), instr_valid, 1'b1);
            check($sformatf("hold_op_%0d", c),    instr_op,    8'hFA);
            check($sformatf("hold_imm_%0d", c),   instr_imm,   16'hDDDD);
            check($sformatf("hold_len_%0d", c),   instr_len,   2'd3);
            check($sformatf("hold_adr_%0d", c),   mem_adr,     16'h0003);
            tick();
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("hold_after_valid", instr_valid, 1'b0);
        check("hold_after_adr",   mem_adr,     16'h0003);

        // ---------------- CB C3 at 0019 ----------------
        clear_mem();
        mem[16'h0019] = 8'hCB; mem[16'h001A] = 8'hC3;
        do_reset();
        redirect_to(16'h0019);
        wait_valid("cb_wait", 10);
        check("cb_flag", instr_cb,      1'b1);
        check("cb_op",   instr_op,      8'hC3);
        check("cb_len",  instr_len,     2'd2);
        check("cb_pc",   instr_pc,      16'h0019);
        check("cb_ill",  instr_illegal, 1'b0);

        // ---------------- D3 illegal at 0000 ----------------
        clear_mem();
        mem[0] = 8'hD3;
        do_reset();
        wait_valid("ill_wait", 10);
        check("ill_flag", instr_illegal, 1'b1);
        check("ill_len",  instr_len,     2'd1);
        check("ill_op",   instr_op,      8'hD3);
        check("ill_cb",   instr_cb,      1'b0);

        // ---------------- store during FETCH_LO ----------------
        clear_mem();
        mem[0] = 8'hC6; mem[1] = 8'hA1;
        do_reset();
        tick();                                   // now in FETCH_LO
        exe_req = 1'b1; exe_we = 1'b1; exe_adr = 16'hEEEE; exe_wdata = 8'h5A;
        #1;
        check("st_wr_en", mem_wr_en, 1'b1);
        check("st_adr",   mem_adr,   16'hEEEE);
        tick();
        exe_req = 1'b0; exe_we = 1'b0;
        #1;
        check("st_stall_valid", instr_valid, 1'b0);
        check("st_stall_adr",   mem_adr,     16'h0001);
        tick();
        check("st_valid", instr_valid, 1'b1);
        check("st_op",    instr_op,    8'hC6);
        check("st_imm",   instr_imm,   16'h00A1);
        exe_req = 1'b1; exe_we = 1'b0; exe_adr = 16'hEEEE;
        #1;
        check("ld_rdata", exe_rdata, 8'h5A);
        check("ld_wr_en", mem_wr_en, 1'b0);
        tick();
        exe_req = 1'b0;

        // ---------------- redirect in FETCH_HI ----------------
        clear_mem();
        mem[0] = 8'h01; mem[1] = 8'h34; mem[2] = 8'h12; mem[16'h0025] = 8'h04;
        do_reset();
        tick();                                   // FETCH_LO
        tick();                                   // FETCH_HI
        redirect_to(16'h0025);
        check("rd_flush_valid", instr_valid, 1'b0);
        check("rd_adr",         mem_adr,     16'h0025);
        wait_valid("rd_wait", 10);
        check("rd_pc", instr_pc, 16'h0025);
        check("rd_op", instr_op, 8'h04);

        // ---------------- opcode 01 at FFFE, PC wrap ----------------
        clear_mem();
        mem[16'hFFFE] = 8'h01; mem[16'hFFFF] = 8'h78; mem[16'h0000] = 8'h56;
        do_reset();
        redirect_to(16'hFFFE);
        wait_valid("wrap_wait", 10);
        check("wrap_op",  instr_op,  8'h01);
        check("wrap_imm", instr_imm, 16'h5678);
        check("wrap_len", instr_len, 2'd3);
        check("wrap_pc",  instr_pc,  16'hFFFE);
        check("wrap_adr", mem_adr,   16'h0001);
`else
        // ---------------- prefetch invalidation by store ----------------
        clear_mem();
        mem[0] = 8'h04; mem[1] = 8'h05;
        do_reset();
        wait_valid("pf_wait", 10);
        check("pf_first_op", instr_op, 8'h04);
        tick();                                   // buffer holds byte at 0001
        exe_req = 1'b1; exe_we = 1'b1; exe_adr = 16'h0001; exe_wdata = 8'h3C;
        tick();
        exe_req = 1'b0; exe_we = 1'b0;
        check("pf_mem_written", mem[1], 8'h3C);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        wait_valid("pf_wait2", 10);
        check("pf_new_op", instr_op, 8'h3C);
        check("pf_new_pc", instr_pc, 16'h0001);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
